serial_complementer: RTL and testbench

//  Parametrised, bit-serial ones'/twos' complement unit. It succeeds the fixed 8-bit combinational inverter.
//  - Accepts a WIDTH-bit operand over a valid/ready handshake.
//  - Processes one bit per clock, LSB first, and streams each result bit out.
//  - Presents the full parallel result and an overflow flag under a valid/ready handshake.
//  - Sits between the operand register file and the ALU result mux; it trades latency for area.

---
 rtl/serial_complementer.sv | 198 +++++++++++++++++++
 tb/tb_serial_complementer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_complementer.sv
// -----------------------------------------------------------------------------
// serial_complementer
//   Bit-serial ones'/twos' complement unit. The block accepts a WIDTH-bit
//   operand over a valid/ready handshake. It processes one bit per clock, LSB
//   first, and streams each result bit. It then presents the parallel result
//   and an overflow flag until the consumer accepts them.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand/mode valid
//   in_ready   operand can be accepted (IDLE only)
//   in_data    operand, sampled at the accept edge only
//   in_mode    0 = ones' complement, 1 = twos' complement
//   abort      cancels an operation in SHIFT; ignored in IDLE and DONE
//   ser_bit    current result bit, LSB first (0 when not shifting)
//   ser_valid  ser_bit is valid this cycle
//   out_valid  parallel result valid
//   out_ready  consumer accepts the result
//   out_data   complemented result (0 when not in DONE)
//   out_ovf    twos' mode with an operand that is 1 followed by WIDTH-1 zeros
// -----------------------------------------------------------------------------
module serial_complementer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic             abort,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             seen_q, seen_d;
  logic             ovf_q, ovf_d;

  logic             bit_s;
  logic             res_bit_s;
  logic             last_s;

  // Twos' complement: bits up to and including the first 1 pass through.
  // Every bit after that 1 is inverted.
  assign bit_s     = op_q[0];
  assign res_bit_s = mode_q ? (seen_q ? ~bit_s : bit_s) : ~bit_s;
  assign last_s    = (cnt_q == LAST_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort takes priority over completion of the final bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: load at accept, then shift one bit per SHIFT cycle.
  always_comb begin
    op_d   = op_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    seen_d = seen_q;
    ovf_d  = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = in_data;
          mode_d = in_mode;
          res_d  = '0;
          cnt_d  = '0;
          seen_d = 1'b0;
          ovf_d  = 1'b0;
        end else begin
          op_d = op_q;
        end
      end
      SHIFT: begin
        if (!abort) begin
          op_d   = op_q >> 1;
          res_d  = {res_bit_s, res_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CW'(1);
          seen_d = seen_q | bit_s;
          if (last_s) begin
            // The MSB is set and no lower bit was 1, so no positive counterpart exists.
            ovf_d = mode_q & bit_s & ~seen_q;
          end else begin
            ovf_d = ovf_q;
          end
        end else begin
          op_d = op_q;
        end
      end
      default: begin
        op_d = op_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      seen_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      op_q   <= op_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      seen_q <= seen_d;
      ovf_q  <= ovf_d;
    end
  end

  // Outputs are decoded from registered state only. Result fields are masked
  // outside DONE, so partial or aborted results are never visible.
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_ovf   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_bit   = res_bit_s;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = res_q;
        out_ovf   = ovf_q;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_complementer.sv
module tb_serial_complementer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_mode;
  logic         abort;
  logic         ser_bit;
  logic         ser_valid;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;

  serial_complementer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .abort     (abort),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: ones' complement is 255-x, twos' complement is 256-x (mod 256).
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] x, input logic m);
    if (m) return W'(9'd256 - {1'b0, x});
    else   return W'(8'd255 - x);
  endfunction

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout: in_ready=%b expected 1", name, in_ready);
    end
  endtask

  task automatic accept(input logic [W-1:0] x, input logic m);
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    tick();
    in_valid = 1'b0;
    // Operand inputs change after the accept edge; the operation must ignore this.
    in_data  = W'($urandom);
    in_mode  = 1'($urandom);
  endtask

  // Full operation: serial stream, latency, result, backpressure and handoff.
  task automatic do_op(input logic [W-1:0] x, input logic m, input int bp,
                       input logic ab_in_done, input string name);
    logic [W-1:0] exp;
    logic         eo;
    exp = ref_result(x, m);
    eo  = m && (x == 8'h80);
    wait_ready(name);
    accept(x, m);
    for (int i = 0; i < W; i++) begin
      checks++;
      if (ser_valid !== 1'b1 || ser_bit !== exp[i] || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_ser%0d: ser_valid=%b ser_bit=%b out_valid=%b in_ready=%b expected 1 %b 0 0",
                 name, i, ser_valid, ser_bit, out_valid, in_ready, exp[i]);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_latency: out_valid=%b ser_valid=%b expected 1 0", name, out_valid, ser_valid);
    end
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL %s_data: out_data=%h expected %h", name, out_data, exp);
    end
    checks++;
    if (out_ovf !== eo) begin
      errors++;
      $display("FAIL %s_ovf: out_ovf=%b expected %b", name, out_ovf, eo);
    end
    for (int j = 0; j < bp; j++) begin
      out_ready = 1'b0;
      abort     = ab_in_done;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || out_ovf !== eo || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold%0d: out_valid=%b out_data=%h out_ovf=%b in_ready=%b expected 1 %h %b 0",
                 name, j, out_valid, out_data, out_ovf, in_ready, exp, eo);
      end
    end
    abort     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b expected 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    #23;
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || ser_bit !== 1'b0 || ser_valid !== 1'b0 ||
        out_valid !== 1'b0 || out_data !== 8'h00 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b sb=%b sv=%b ov=%b od=%h of=%b expected 1 0 0 0 00 0",
               in_ready, ser_bit, ser_valid, out_valid, out_data, out_ovf);
    end
  endtask

  task automatic test_ones();
    do_op(8'h0F, 1'b0, 0, 1'b0, "ones_0f");
    do_op(8'hFF, 1'b0, 0, 1'b0, "ones_ff");
  endtask

  task automatic test_twos();
    do_op(8'h06, 1'b1, 0, 1'b0, "twos_06");
    do_op(8'h01, 1'b1, 0, 1'b0, "twos_01");
    do_op(8'h00, 1'b1, 0, 1'b0, "twos_00");
  endtask

  task automatic test_overflow();
    do_op(8'h80, 1'b1, 0, 1'b0, "ovf_80");
    do_op(8'h80, 1'b0, 0, 1'b0, "ones_80");
    do_op(8'hC0, 1'b1, 0, 1'b0, "twos_c0");
  endtask

  task automatic test_backpressure();
    do_op(8'h5A, 1'b1, 5, 1'b0, "bp");
    // Abort is ignored while the result is waiting in DONE.
    do_op(8'h33, 1'b0, 3, 1'b1, "bp_abort");
  endtask

  task automatic test_abort(input int cyc, input string name);
    int bad;
    wait_ready(name);
    accept(8'h3C, 1'b1);
    for (int i = 0; i < cyc - 1; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || ser_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: in_ready=%b ser_valid=%b out_valid=%b expected 1 0 0",
               name, in_ready, ser_valid, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_no_result: out_valid high in %0d cycles expected 0", name, bad);
    end
    do_op(8'h0F, 1'b0, 0, 1'b0, {name, "_after"});
  endtask

  task automatic test_reset_mid();
    wait_ready("rst_mid");
    accept(8'h0F, 1'b1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ser_bit !== 1'b0 || ser_valid !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 8'h00 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: sb=%b sv=%b ov=%b od=%h of=%b expected 0 0 0 00 0",
               ser_bit, ser_valid, out_valid, out_data, out_ovf);
    end
    #3;
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle: in_ready=%b ser_valid=%b expected 1 0", in_ready, ser_valid);
    end
    do_op(8'h0F, 1'b0, 0, 1'b0, "rst_mid_after");
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic         m;
    for (int n = 0; n < 24; n++) begin
      x = W'($urandom);
      m = 1'($urandom);
      do_op(x, m, int'($urandom_range(0, 3)), 1'($urandom), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_twos();
    test_overflow();
    test_backpressure();
    test_abort(4, "abort4");
    test_abort(W, "abort_last");
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
